// File: rtl/mem_settle_checker.sv
// Run monitor: waits for a bank of watched words to stop changing (or for a run timeout),
// then latches the run length and a per-channel compare against expected values.
module mem_settle_checker #(
  parameter int NUM_CH        = 6,
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 8,
  parameter int TIMEOUT       = 1000,
  parameter int CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CH*WIDTH-1:0] mon_bus,
  input  logic [NUM_CH*WIDTH-1:0] exp_bus,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [NUM_CH-1:0]       mismatch_mask,
  output logic [CNT_W-1:0]        cycles
);

  localparam int BUS_W = NUM_CH * WIDTH;
  localparam int SW    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0]    STABLE_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  function automatic logic [NUM_CH-1:0] diff_mask(input logic [BUS_W-1:0] a,
                                                  input logic [BUS_W-1:0] b);
    logic [NUM_CH-1:0] m;
    for (int k = 0; k < NUM_CH; k++) begin
      m[k] = (a[k*WIDTH +: WIDTH] != b[k*WIDTH +: WIDTH]);
    end
    return m;
  endfunction

  state_e            state_q, state_d;
  logic [BUS_W-1:0]  prev_q, prev_d;
  logic [SW-1:0]     stable_q, stable_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              pass_q, pass_d, timeout_q, timeout_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  n_s;
  logic              eq_s, settle_s;
  logic [NUM_CH-1:0] mask_s;

  // Next-state and next-output computation for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    stable_d  = stable_q;
    cycle_d   = cycle_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    mask_d    = mask_q;
    cycles_d  = cycles_q;
    n_s       = cycle_q + CNT_W'(1);
    eq_s      = (mon_bus == prev_q);
    settle_s  = eq_s && (stable_q == STABLE_MAX);
    mask_s    = diff_mask(mon_bus, exp_bus);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          prev_d   = mon_bus;
          stable_d = '0;
          cycle_d  = '0;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          // Result outputs from the previous run are deliberately left intact
          state_d  = IDLE;
          busy_d   = 1'b0;
          stable_d = '0;
          cycle_d  = '0;
        end else begin
          prev_d  = mon_bus;
          cycle_d = n_s;
          if (!eq_s) begin
            stable_d = '0;
          end else if (stable_q != STABLE_MAX) begin
            stable_d = stable_q + SW'(1);
          end else begin
            stable_d = stable_q;
          end
          if (settle_s) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b0;
            cycles_d  = n_s;
            mask_d    = mask_s;
            pass_d    = (mask_s == '0);
          end else if (n_s == TIMEOUT_C) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            cycles_d  = n_s;
            mask_d    = mask_s;
            pass_d    = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else if (start) begin
          state_d  = RUN;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          prev_d   = mon_bus;
          stable_d = '0;
          cycle_d  = '0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      stable_q  <= '0;
      cycle_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      mask_q    <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      cycle_q   <= cycle_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      mask_q    <= mask_d;
      cycles_q  <= cycles_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign mismatch_mask = mask_q;
  assign cycles        = cycles_q;

endmodule

// File: tb/tb_mem_settle_checker.sv
// Directed bench for mem_settle_checker: four instances cover the default, timeout,
// single-cycle-settle and settle-vs-timeout parameterisations.
module tb_mem_settle_checker;

  localparam int BW = 96;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, abort;
  logic start_m, start_t, start_s, start_e;
  logic [BW-1:0] mon_bus, exp_bus, fin_bad;

  logic busy_m, done_m, pass_m, to_m; logic [5:0] mask_m; logic [15:0] cyc_m;
  logic busy_t, done_t, pass_t, to_t; logic [5:0] mask_t; logic [15:0] cyc_t;
  logic busy_s, done_s, pass_s, to_s; logic [5:0] mask_s; logic [15:0] cyc_s;
  logic busy_e, done_e, pass_e, to_e; logic [5:0] mask_e; logic [15:0] cyc_e;

  int n_tests = 0;
  int n_fail  = 0;

  mem_settle_checker #(.NUM_CH(6), .WIDTH(16), .STABLE_CYCLES(8), .TIMEOUT(1000), .CNT_W(16)) u_m (
    .clk(clk), .rst_n(rst_n), .start(start_m), .abort(abort), .mon_bus(mon_bus), .exp_bus(exp_bus),
    .busy(busy_m), .done(done_m), .pass(pass_m), .timeout(to_m), .mismatch_mask(mask_m), .cycles(cyc_m));
  mem_settle_checker #(.NUM_CH(6), .WIDTH(16), .STABLE_CYCLES(8), .TIMEOUT(50), .CNT_W(16)) u_t (
    .clk(clk), .rst_n(rst_n), .start(start_t), .abort(abort), .mon_bus(mon_bus), .exp_bus(exp_bus),
    .busy(busy_t), .done(done_t), .pass(pass_t), .timeout(to_t), .mismatch_mask(mask_t), .cycles(cyc_t));
  mem_settle_checker #(.NUM_CH(6), .WIDTH(16), .STABLE_CYCLES(1), .TIMEOUT(1000), .CNT_W(16)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort), .mon_bus(mon_bus), .exp_bus(exp_bus),
    .busy(busy_s), .done(done_s), .pass(pass_s), .timeout(to_s), .mismatch_mask(mask_s), .cycles(cyc_s));
  mem_settle_checker #(.NUM_CH(6), .WIDTH(16), .STABLE_CYCLES(8), .TIMEOUT(8), .CNT_W(16)) u_e (
    .clk(clk), .rst_n(rst_n), .start(start_e), .abort(abort), .mon_bus(mon_bus), .exp_bus(exp_bus),
    .busy(busy_e), .done(done_e), .pass(pass_e), .timeout(to_e), .mismatch_mask(mask_e), .cycles(cyc_e));

  function automatic logic [BW-1:0] pat(input int i);
    logic [BW-1:0] v;
    for (int k = 0; k < 6; k++) v[k*16 +: 16] = 16'h1000 + 16'(i) + 16'(k);
    return v;
  endfunction

  // Start u_m with bus at zero, change for cycles 1..chg-1, present fin from cycle chg on
  // (chg==0: fin held from before start). done_at = RUN cycle after which done was seen.
  task automatic run_main(input logic [BW-1:0] fin, input int chg, output int done_at);
    done_at = 0;
    mon_bus = (chg == 0) ? fin : '0;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    for (int i = 1; i <= 60 && done_at == 0; i++) begin
      mon_bus = (i < chg) ? pat(i) : fin;
      @(negedge clk);
      if (done_m) done_at = i;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; abort = 1'b0; mon_bus = '0;
    start_m = 1'b0; start_t = 1'b0; start_s = 1'b0; start_e = 1'b0;
    #12;
    n_tests++;
    if ({busy_m, done_m, pass_m, to_m, mask_m, cyc_m} !== 26'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", {busy_m, done_m, pass_m, to_m, mask_m, cyc_m});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_settle_pass();
    int d;
    mon_bus = '0; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    n_tests++;
    if (busy_m !== 1'b1) begin n_fail++; $display("FAIL settle_busy got %b want 1", busy_m); end
    @(negedge clk);
    start_m = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; start_m = 1'b0;
    run_main(exp_bus, 20, d);
    n_tests++;
    if (d !== 28) begin n_fail++; $display("FAIL settle_done_cycle got %0d want 28", d); end
    n_tests++;
    if (cyc_m !== 16'd28) begin n_fail++; $display("FAIL settle_cycles got %0d want 28", cyc_m); end
    n_tests++;
    if ({pass_m, to_m, mask_m, busy_m} !== {1'b1, 1'b0, 6'b0, 1'b0}) begin
      n_fail++; $display("FAIL settle_flags got p=%b t=%b m=%b b=%b want p=1 t=0 m=0 b=0", pass_m, to_m, mask_m, busy_m);
    end
  endtask

  task automatic test_mismatch();
    int d;
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    run_main(fin_bad, 20, d);
    n_tests++;
    if (d !== 28 || cyc_m !== 16'd28) begin n_fail++; $display("FAIL mismatch_cycles got %0d/%0d want 28", d, cyc_m); end
    n_tests++;
    if ({pass_m, to_m, mask_m} !== {1'b0, 1'b0, 6'b001000}) begin
      n_fail++; $display("FAIL mismatch_flags got p=%b t=%b m=%b want p=0 t=0 m=001000", pass_m, to_m, mask_m);
    end
  endtask

  task automatic test_timeout();
    mon_bus = '0; start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      mon_bus = (i % 2 == 1) ? {BW{1'b1}} : {BW{1'b0}};
      @(negedge clk);
      if (i == 49) begin
        n_tests++;
        if (done_t !== 1'b0 || busy_t !== 1'b1) begin
          n_fail++; $display("FAIL timeout_early got done=%b busy=%b want 0/1", done_t, busy_t);
        end
      end
    end
    n_tests++;
    if ({done_t, to_t, pass_t, cyc_t} !== {1'b1, 1'b1, 1'b0, 16'd50}) begin
      n_fail++; $display("FAIL timeout_result got d=%b t=%b p=%b c=%0d want d=1 t=1 p=0 c=50", done_t, to_t, pass_t, cyc_t);
    end
  endtask

  task automatic test_boundary();
    mon_bus = exp_bus; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({done_s, cyc_s, pass_s, to_s} !== {1'b1, 16'd1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL stable1 got d=%b c=%0d p=%b t=%b want d=1 c=1 p=1 t=0", done_s, cyc_s, pass_s, to_s);
    end
    start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    repeat (7) @(negedge clk);
    n_tests++;
    if (done_e !== 1'b0) begin n_fail++; $display("FAIL settle_wins_early got done=%b want 0", done_e); end
    @(negedge clk);
    n_tests++;
    if ({done_e, to_e, pass_e, cyc_e} !== {1'b1, 1'b0, 1'b1, 16'd8}) begin
      n_fail++; $display("FAIL settle_wins got d=%b t=%b p=%b c=%0d want d=1 t=0 p=1 c=8", done_e, to_e, pass_e, cyc_e);
    end
  endtask

  task automatic test_abort_restart();
    int d;
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    mon_bus = '0; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      mon_bus = pat(i);
      abort = (i == 5);
      @(negedge clk);
    end
    abort = 1'b0;
    n_tests++;
    if ({busy_m, done_m, mask_m, cyc_m} !== {1'b0, 1'b0, 6'b001000, 16'd28}) begin
      n_fail++; $display("FAIL abort_state got b=%b d=%b m=%b c=%0d want b=0 d=0 m=001000 c=28", busy_m, done_m, mask_m, cyc_m);
    end
    run_main(exp_bus, 0, d);
    n_tests++;
    if (d !== 8 || cyc_m !== 16'd8 || pass_m !== 1'b1) begin
      n_fail++; $display("FAIL abort_fresh got at=%0d c=%0d p=%b want 8/8/1", d, cyc_m, pass_m);
    end
  endtask

  task automatic test_back_to_back();
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    n_tests++;
    if (done_m !== 1'b0 || busy_m !== 1'b1) begin
      n_fail++; $display("FAIL restart_from_done got d=%b b=%b want 0/1", done_m, busy_m);
    end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    n_tests++;
    if (busy_m !== 1'b0) begin n_fail++; $display("FAIL restart_abort got busy=%b want 0", busy_m); end
  endtask

  task automatic test_reset_mid_run();
    int d;
    mon_bus = '0; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      mon_bus = pat(i);
      @(negedge clk);
    end
    n_tests++;
    if (busy_m !== 1'b1) begin n_fail++; $display("FAIL midrun_busy got %b want 1", busy_m); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy_m, done_m, pass_m, to_m, mask_m, cyc_m, done_t, to_t, cyc_t} !== 44'd0) begin
      n_fail++; $display("FAIL midrun_reset got m=%h t=%b%b%0d want 0",
                         {busy_m, done_m, pass_m, to_m, mask_m, cyc_m}, done_t, to_t, cyc_t);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_main(exp_bus, 0, d);
    n_tests++;
    if (d !== 8 || cyc_m !== 16'd8 || pass_m !== 1'b1 || to_m !== 1'b0) begin
      n_fail++; $display("FAIL after_reset got at=%0d c=%0d p=%b t=%b want 8/8/1/0", d, cyc_m, pass_m, to_m);
    end
  endtask

  initial begin
    for (int k = 0; k < 6; k++) exp_bus[k*16 +: 16] = 16'h00A0 + 16'(k);
    fin_bad = exp_bus;
    fin_bad[3*16 +: 16] = 16'h00A5;
    test_reset();
    test_settle_pass();
    test_mismatch();
    test_timeout();
    test_boundary();
    test_abort_restart();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
